// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types and constants for the victim-selection path.
package hpdcache_pkg;

  // Replacement policies understood by the victim selector.
  typedef enum logic [1:0] {
    HPDCACHE_VICTIM_RANDOM = 2'd0,
    HPDCACHE_VICTIM_RR     = 2'd1,
    HPDCACHE_VICTIM_SRRIP  = 2'd2
  } hpdcache_victim_sel_policy_t;

  // 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 feed back).
  localparam logic [7:0] HPDCACHE_VICTIM_LFSR_SEED = 8'h01;
  localparam logic [7:0] HPDCACHE_VICTIM_LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] hpdcache_victim_lfsr_next(input logic [7:0] state);
    return {state[6:0], ^(state & HPDCACHE_VICTIM_LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/hpdcache_rotate_first_one.sv
// Finds the first set bit at or after a start index, wrapping around the vector.
module hpdcache_rotate_first_one #(
  parameter int unsigned N = 8,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    vec_i,
  input  logic [IdxW-1:0] start_i,
  output logic [N-1:0]    onehot_o,
  output logic [IdxW-1:0] idx_o,
  output logic            found_o
);

  logic [IdxW-1:0] pos;

  // Walk positions start, start+1, ... (mod N) and latch the first hit.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    pos      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = IdxW'((32'(start_i) + i) % N);
      if (!found_o && vec_i[pos]) begin
        onehot_o[pos] = 1'b1;
        idx_o         = pos;
        found_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpdcache_victim_sel_masked.sv
// Multi-policy victim selector with a per-request way-eligibility mask.
module hpdcache_victim_sel_masked
  import hpdcache_pkg::*;
#(
  parameter int unsigned                 SETS       = 64,
  parameter int unsigned                 WAYS       = 8,
  parameter hpdcache_victim_sel_policy_t POLICY     = HPDCACHE_VICTIM_SRRIP,
  parameter int unsigned                 RRPV_WIDTH = 2,
  localparam int unsigned                SetW       = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            updt_i,
  input  logic [SetW-1:0] updt_set_i,
  input  logic [WAYS-1:0] updt_way_i,
  input  logic            repl_i,
  input  logic [SetW-1:0] repl_set_i,
  input  logic [WAYS-1:0] repl_dir_valid_i,
  input  logic [WAYS-1:0] repl_way_mask_i,
  input  logic            repl_updt_i,
  output logic [WAYS-1:0] victim_way_o,
  output logic            victim_valid_o
);

  localparam int unsigned WayW = (WAYS > 1) ? $clog2(WAYS) : 1;

  if (WAYS == 1) begin : g_single
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_i, updt_i, updt_set_i, updt_way_i, repl_i, repl_set_i,
                             repl_dir_valid_i, repl_updt_i};

    // A single way is the victim exactly when it is eligible; no state is kept.
    always_comb begin
      victim_way_o   = repl_way_mask_i;
      victim_valid_o = repl_way_mask_i[0];
    end
  end else begin : g_multi
    logic [WAYS-1:0] inv_onehot;
    logic [WayW-1:0] inv_idx;
    logic            has_inv;
    logic            any_elig;
    logic            commit;

    // Lowest-index eligible invalid way always wins over the policy.
    hpdcache_rotate_first_one #(
      .N(WAYS)
    ) u_inv_first (
      .vec_i   (repl_way_mask_i & ~repl_dir_valid_i),
      .start_i ('0),
      .onehot_o(inv_onehot),
      .idx_o   (inv_idx),
      .found_o (has_inv)
    );

    assign any_elig = |repl_way_mask_i;
    assign commit   = repl_i & repl_updt_i & any_elig;

    if (POLICY == HPDCACHE_VICTIM_RANDOM) begin : g_random
      logic [7:0]      lfsr_q, lfsr_d;
      logic [WayW-1:0] rnd_start;
      logic [WAYS-1:0] rnd_onehot;
      logic [WayW-1:0] unused_rnd_idx;
      logic            unused_rnd_found;
      logic            unused_inputs;

      assign unused_inputs = ^{updt_i, updt_set_i, updt_way_i, repl_set_i, repl_updt_i,
                               inv_idx, commit, unused_rnd_idx, unused_rnd_found};

      hpdcache_rotate_first_one #(
        .N(WAYS)
      ) u_rnd_first (
        .vec_i   (repl_way_mask_i),
        .start_i (rnd_start),
        .onehot_o(rnd_onehot),
        .idx_o   (unused_rnd_idx),
        .found_o (unused_rnd_found)
      );

      // Pick from the LFSR start point; the LFSR advances on every policy-driven request.
      always_comb begin
        rnd_start      = WayW'(32'(lfsr_q) % WAYS);
        victim_way_o   = has_inv ? inv_onehot : rnd_onehot;
        victim_valid_o = any_elig;
        lfsr_d         = lfsr_q;
        if (repl_i && any_elig && !has_inv) begin
          lfsr_d = hpdcache_victim_lfsr_next(lfsr_q);
        end
      end

      // LFSR state register.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          lfsr_q <= HPDCACHE_VICTIM_LFSR_SEED;
        end else begin
          lfsr_q <= lfsr_d;
        end
      end
    end else if (POLICY == HPDCACHE_VICTIM_RR) begin : g_rr
      logic [WayW-1:0] ptr_q [SETS];
      logic [WayW-1:0] ptr_d [SETS];
      logic [WayW-1:0] rr_start;
      logic [WAYS-1:0] rr_onehot;
      logic [WayW-1:0] rr_idx;
      logic            unused_rr_found;
      logic            unused_inputs;

      assign unused_inputs = ^{updt_i, updt_set_i, updt_way_i, inv_idx, unused_rr_found};
      assign rr_start      = ptr_q[repl_set_i];

      hpdcache_rotate_first_one #(
        .N(WAYS)
      ) u_rr_first (
        .vec_i   (repl_way_mask_i),
        .start_i (rr_start),
        .onehot_o(rr_onehot),
        .idx_o   (rr_idx),
        .found_o (unused_rr_found)
      );

      // Select from the set pointer; a committed policy pick moves the pointer past it.
      always_comb begin
        victim_way_o   = has_inv ? inv_onehot : rr_onehot;
        victim_valid_o = any_elig;
        ptr_d          = ptr_q;
        if (commit && !has_inv) begin
          ptr_d[repl_set_i] = WayW'((32'(rr_idx) + 1) % WAYS);
        end
      end

      // Per-set pointer registers.
      always_ff @(posedge clk_i) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          if (rst_i) begin
            ptr_q[s] <= '0;
          end else begin
            ptr_q[s] <= ptr_d[s];
          end
        end
      end
    end else begin : g_srrip
      localparam logic [RRPV_WIDTH-1:0] MaxRrpv    = '1;
      localparam logic [RRPV_WIDTH-1:0] InsertRrpv = MaxRrpv - RRPV_WIDTH'(1);

      logic [RRPV_WIDTH-1:0] rrpv_q [SETS][WAYS];
      logic [RRPV_WIDTH-1:0] rrpv_d [SETS][WAYS];
      logic [RRPV_WIDTH-1:0] max_rrpv;
      logic [WAYS-1:0]       cand;
      logic [WAYS-1:0]       cand_onehot;
      logic [WayW-1:0]       cand_idx;
      logic                  unused_cand_found;
      logic [WAYS-1:0]       sel_onehot;
      logic [WayW-1:0]       sel_idx;

      // Maximum RRPV among eligible ways and the ways that reach it.
      always_comb begin
        max_rrpv = '0;
        cand     = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (repl_way_mask_i[w] && (rrpv_q[repl_set_i][w] > max_rrpv)) begin
            max_rrpv = rrpv_q[repl_set_i][w];
          end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
          cand[w] = repl_way_mask_i[w] && (rrpv_q[repl_set_i][w] == max_rrpv);
        end
      end

      hpdcache_rotate_first_one #(
        .N(WAYS)
      ) u_srrip_first (
        .vec_i   (cand),
        .start_i ('0),
        .onehot_o(cand_onehot),
        .idx_o   (cand_idx),
        .found_o (unused_cand_found)
      );

      // Victim choice plus next RRPVs: age, insert, then promote unless the hit is the victim.
      always_comb begin
        sel_onehot     = has_inv ? inv_onehot : cand_onehot;
        sel_idx        = has_inv ? inv_idx : cand_idx;
        victim_way_o   = sel_onehot;
        victim_valid_o = any_elig;
        rrpv_d         = rrpv_q;
        if (commit) begin
          if (!has_inv) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
              if (repl_way_mask_i[w]) begin
                rrpv_d[repl_set_i][w] = rrpv_q[repl_set_i][w] + (MaxRrpv - max_rrpv);
              end
            end
          end
          rrpv_d[repl_set_i][sel_idx] = InsertRrpv;
        end
        if (updt_i) begin
          for (int unsigned w = 0; w < WAYS; w++) begin
            if (updt_way_i[w] &&
                !(commit && (updt_set_i == repl_set_i) && sel_onehot[w])) begin
              rrpv_d[updt_set_i][w] = '0;
            end
          end
        end
      end

      // Per-set, per-way RRPV registers.
      always_ff @(posedge clk_i) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          for (int unsigned w = 0; w < WAYS; w++) begin
            if (rst_i) begin
              rrpv_q[s][w] <= MaxRrpv;
            end else begin
              rrpv_q[s][w] <= rrpv_d[s][w];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hpdcache_victim_sel_masked.sv
// Directed bench for the masked victim selector: SRRIP, RR and RANDOM instances share stimulus.
module tb_hpdcache_victim_sel_masked;
  import hpdcache_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i, updt_i, repl_i, repl_updt_i;
  logic [1:0] updt_set_i, repl_set_i;
  logic [3:0] updt_way_i, repl_dir_valid_i, repl_way_mask_i;
  logic [3:0] vs_way, vr_way, vn_way;
  logic       vs_vld, vr_vld, vn_vld;

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0] dut;
    logic [3:0] way;
    logic       vld;
  } exp_t;

  exp_t       sb[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_errs = 0;
  logic [7:0] lfsr_m;
  logic [1:0] ptr_m [4];

  hpdcache_victim_sel_masked #(
    .SETS(4), .WAYS(4), .POLICY(HPDCACHE_VICTIM_SRRIP), .RRPV_WIDTH(2)
  ) u_srrip (
    .clk_i(clk_i), .rst_i(rst_i), .updt_i(updt_i), .updt_set_i(updt_set_i),
    .updt_way_i(updt_way_i), .repl_i(repl_i), .repl_set_i(repl_set_i),
    .repl_dir_valid_i(repl_dir_valid_i), .repl_way_mask_i(repl_way_mask_i),
    .repl_updt_i(repl_updt_i), .victim_way_o(vs_way), .victim_valid_o(vs_vld)
  );

  hpdcache_victim_sel_masked #(
    .SETS(4), .WAYS(4), .POLICY(HPDCACHE_VICTIM_RR), .RRPV_WIDTH(2)
  ) u_rr (
    .clk_i(clk_i), .rst_i(rst_i), .updt_i(updt_i), .updt_set_i(updt_set_i),
    .updt_way_i(updt_way_i), .repl_i(repl_i), .repl_set_i(repl_set_i),
    .repl_dir_valid_i(repl_dir_valid_i), .repl_way_mask_i(repl_way_mask_i),
    .repl_updt_i(repl_updt_i), .victim_way_o(vr_way), .victim_valid_o(vr_vld)
  );

  hpdcache_victim_sel_masked #(
    .SETS(4), .WAYS(4), .POLICY(HPDCACHE_VICTIM_RANDOM), .RRPV_WIDTH(2)
  ) u_rnd (
    .clk_i(clk_i), .rst_i(rst_i), .updt_i(updt_i), .updt_set_i(updt_set_i),
    .updt_way_i(updt_way_i), .repl_i(repl_i), .repl_set_i(repl_set_i),
    .repl_dir_valid_i(repl_dir_valid_i), .repl_way_mask_i(repl_way_mask_i),
    .repl_updt_i(repl_updt_i), .victim_way_o(vn_way), .victim_valid_o(vn_vld)
  );

  function automatic logic [3:0] first_from(input logic [3:0] v, input int s);
    logic [1:0] j;
    for (int i = 0; i < 4; i++) begin
      j = 2'((s + i) % 4);
      if (v[j]) return 4'(1 << j);
    end
    return 4'b0000;
  endfunction

  function automatic int idx_of(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) return i;
    end
    return 0;
  endfunction

  task automatic push(input string t, input logic [1:0] d, input logic [3:0] w, input logic v);
    exp_t e;
    e.dut = d;
    e.way = w;
    e.vld = v;
    sb.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check_sb();
    exp_t       e;
    string      t;
    logic [3:0] ow;
    logic       ov;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      t = tag_q.pop_front();
      case (e.dut)
        2'd0:    begin ow = vs_way; ov = vs_vld; end
        2'd1:    begin ow = vr_way; ov = vr_vld; end
        default: begin ow = vn_way; ov = vn_vld; end
      endcase
      n_checks++;
      assert ({ow, ov} === {e.way, e.vld}) else begin
        n_errs++;
        $error("FAIL %s: got way=%b valid=%b, expected way=%b valid=%b", t, ow, ov, e.way, e.vld);
      end
    end
  endtask

  // Compare mid-cycle, advance the reference models, then take the edge and release strobes.
  task automatic step();
    @(negedge clk_i);
    check_sb();
    if (rst_i) begin
      lfsr_m = 8'h01;
      for (int i = 0; i < 4; i++) ptr_m[i] = 2'd0;
    end else if (repl_i && (repl_way_mask_i != 4'b0000) &&
                 ((repl_way_mask_i & ~repl_dir_valid_i) == 4'b0000)) begin
      lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
    end
    @(posedge clk_i);
    #1;
    rst_i       = 1'b0;
    updt_i      = 1'b0;
    repl_i      = 1'b0;
    repl_updt_i = 1'b0;
  endtask

  task automatic hit(input logic [1:0] s, input logic [3:0] w);
    updt_i     = 1'b1;
    updt_set_i = s;
    updt_way_i = w;
  endtask

  task automatic req(input logic [1:0] s, input logic [3:0] dv, input logic [3:0] m,
                     input logic c, input logic chk_s, input logic [3:0] exp_s, input string t);
    logic [3:0] inv, rr_w, rn_w;
    repl_i           = 1'b1;
    repl_set_i       = s;
    repl_dir_valid_i = dv;
    repl_way_mask_i  = m;
    repl_updt_i      = c;
    inv  = m & ~dv;
    rr_w = (inv != 4'b0000) ? first_from(inv, 0) : first_from(m, int'(ptr_m[s]));
    rn_w = (inv != 4'b0000) ? first_from(inv, 0) : first_from(m, int'(lfsr_m[1:0]));
    if (chk_s) push(t, 2'd0, exp_s, m != 4'b0000);
    push({t, "_rr"}, 2'd1, rr_w, m != 4'b0000);
    push({t, "_rnd"}, 2'd2, rn_w, m != 4'b0000);
    if (c && (m != 4'b0000) && (inv == 4'b0000)) ptr_m[s] = 2'((idx_of(rr_w) + 1) % 4);
  endtask

  // Drive a set's RRPVs to {0,1,2,1} (way0..way3) from any starting state.
  task automatic build_0121(input logic [1:0] s, input string t);
    for (int i = 0; i < 4; i++) begin
      hit(s, 4'(1 << i));
      step();
    end
    req(s, 4'hF, 4'b0100, 1'b1, 1'b1, 4'b0100, {t, "_a"});
    step();
    req(s, 4'hF, 4'b1100, 1'b1, 1'b1, 4'b0100, {t, "_b"});
    step();
    req(s, 4'hF, 4'b0110, 1'b1, 1'b1, 4'b0100, {t, "_c"});
    step();
  endtask

  initial begin
    rst_i = 1'b1; updt_i = 1'b0; repl_i = 1'b0; repl_updt_i = 1'b0;
    updt_set_i = '0; updt_way_i = '0; repl_set_i = '0;
    repl_dir_valid_i = '0; repl_way_mask_i = '0;
    lfsr_m = 8'h01;
    for (int i = 0; i < 4; i++) ptr_m[i] = 2'd0;
    step();

    // Reset state
    req(2'd0, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0001, "rst_state");
    step();

    // Invalid way first, insertion without aging
    req(2'd2, 4'b1011, 4'hF, 1'b1, 1'b1, 4'b0100, "inv_way");
    step();
    req(2'd2, 4'hF, 4'b1100, 1'b0, 1'b1, 4'b1000, "inv_rrpv");
    step();
    req(2'd2, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0001, "inv_others");
    step();

    // Aging in set 1
    build_0121(2'd1, "build1");
    req(2'd1, 4'hF, 4'hF, 1'b1, 1'b1, 4'b0100, "age_victim");
    step();
    req(2'd1, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0010, "age_next");
    step();

    // Masking
    req(2'd1, 4'hF, 4'b0000, 1'b1, 1'b1, 4'b0000, "mask_none");
    step();
    req(2'd1, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0010, "mask_none_keep");
    step();
    req(2'd1, 4'hF, 4'b1000, 1'b0, 1'b1, 4'b1000, "mask_hi");
    step();

    // Hit and commit in the same set
    build_0121(2'd3, "build3");
    req(2'd3, 4'hF, 4'hF, 1'b1, 1'b1, 4'b0100, "collide_victim");
    hit(2'd3, 4'b0010);
    step();
    req(2'd3, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0100, "collide_max");
    step();
    req(2'd3, 4'hF, 4'b0011, 1'b0, 1'b1, 4'b0001, "collide_hit");
    step();

    // Reset in mid-sequence with a simultaneous commit and hit
    rst_i = 1'b1;
    req(2'd3, 4'hF, 4'b1010, 1'b1, 1'b1, 4'b1000, "rst_cycle");
    hit(2'd3, 4'b0001);
    step();
    req(2'd3, 4'hF, 4'b1010, 1'b0, 1'b1, 4'b0010, "rst_rrpv");
    step();
    req(2'd3, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0001, "rst_all");
    step();

    // RR wrap in set 0: pointer to 3, then wrap to way 0 and advance to 1
    req(2'd0, 4'hF, 4'b0100, 1'b1, 1'b1, 4'b0100, "rr_setup");
    step();
    req(2'd0, 4'hF, 4'b0011, 1'b1, 1'b1, 4'b0001, "rr_wrap_s");
    push("rr_wrap", 2'd1, 4'b0001, 1'b1);
    step();
    req(2'd0, 4'hF, 4'b0011, 1'b0, 1'b1, 4'b0010, "rr_next_s");
    push("rr_next", 2'd1, 4'b0010, 1'b1);
    step();

    // Mixed traffic checked against the RR and RANDOM reference models
    for (int i = 0; i < 24; i++) begin
      req(2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 4'b0000, "mix");
      if ($urandom_range(1) == 1) hit(2'($urandom), 4'(1 << $urandom_range(3)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
